stash_path_exerciser: RTL and testbench

- Synthesizable traffic generator and checker for the Stash. Runs one ORAM path access per Start pulse.
- Sequence per access: scan, N block writes with counter data, read phase, then checks of returned data, PAddr, leaf and occupancy.
- Generalises fixed 4-block directed stimulus: block count, beat count and leaf mode are parametrised; results are self-checked and reported as sticky error bits.
- Sits beside the Stash on FPGA bring-up builds and in regression benches.

---
 rtl/stash_path_exerciser.sv | 258 +++++++++++++++++++++++++
 tb/tb_stash_path_exerciser.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stash_path_exerciser.sv
// Stash path-access traffic generator and checker: one scan/write/read/check sequence per Start.
// Optional watchdog enabled by defining STASH_EXERCISER_TIMEOUT_EN.
module stash_path_exerciser #(
    parameter int DataWidth     = 64,
    parameter int ORAMU         = 32,
    parameter int ORAML         = 32,
    parameter int StashEAWidth  = 8,
    parameter int BlocksPerPath = 4,
    parameter int BeatsPerBlock = 8,
    parameter int ScanDelay     = 10
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Mode,
    input  logic [ORAMU-1:0]        BaseAddr,
    input  logic [ORAML-1:0]        AccessLeaf,
    output logic                    StartScanOperation,
    output logic                    StartReadOperation,
    output logic [DataWidth-1:0]    WriteData,
    output logic [ORAMU-1:0]        WritePAddr,
    output logic [ORAML-1:0]        WriteLeaf,
    output logic                    WriteInValid,
    input  logic                    WriteInReady,
    input  logic                    BlockWriteComplete,
    input  logic [DataWidth-1:0]    ReadData,
    input  logic [ORAMU-1:0]        ReadPAddr,
    input  logic [ORAML-1:0]        ReadLeaf,
    input  logic                    ReadOutValid,
    output logic                    ReadOutReady,
    input  logic                    BlockReadComplete,
    input  logic                    PathReadComplete,
    input  logic [StashEAWidth-1:0] StashOccupancy,
    input  logic                    StashOverflow,
    output logic                    Busy,
    output logic                    Done,
    output logic [6:0]              ErrorFlags,
    output logic [15:0]             AccessCount
);
    localparam int IdxW  = (BlocksPerPath > 1) ? $clog2(BlocksPerPath) : 1;
    localparam int BeatW = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;
    localparam int DlyW  = (ScanDelay > 1) ? $clog2(ScanDelay + 1) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, DELAY, WRITE, READ_START, READ, CHECK} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [ORAMU-1:0]        base_q, base_d;
    logic [ORAML-1:0]        leaf_q, leaf_d;
    logic [StashEAWidth-1:0] occ_base_q, occ_base_d;
    logic [6:0]              err_q, err_d;
    logic [BlocksPerPath-1:0] bitmap_q, bitmap_d;
    logic [IdxW-1:0]         blk_q, blk_d;
    logic [DataWidth-1:0]    cnt_q, cnt_d;
    logic [DataWidth-1:0]    dbase_q, dbase_d;
    logic [BeatW-1:0]        rbeat_q, rbeat_d;
    logic                    rbad_q, rbad_d;
    logic [DlyW-1:0]         dly_q, dly_d;
    logic [15:0]             acc_q, acc_d;
    logic                    done_q, done_d;

    // Read-side decode of the beat currently presented by the Stash
    logic                    real_fire;
    logic [ORAMU-1:0]        ridx_full;
    logic [IdxW-1:0]         ridx;
    logic                    beat_bad;
    logic                    blk_bad;
    logic [DataWidth-1:0]    exp_data;

    assign real_fire = (state_q == READ) && ReadOutValid && (ReadPAddr != '1);
    assign ridx_full = ReadPAddr - base_q;
    assign ridx      = ridx_full[IdxW-1:0];
    assign beat_bad  = (ridx_full >= ORAMU'(BlocksPerPath)) || (ReadLeaf != leaf_q);
    assign blk_bad   = rbad_q || beat_bad;
    assign exp_data  = dbase_q + DataWidth'(ridx) * DataWidth'(BeatsPerBlock) + DataWidth'(rbeat_q);

`ifdef STASH_EXERCISER_TIMEOUT_EN
    logic [19:0] wd_q, wd_d;
    logic        wd_expired;
    logic        beat_accept;
    assign wd_expired  = (state_q != IDLE) && (state_q != CHECK) && (wd_q == '1);
    assign beat_accept = (WriteInValid && WriteInReady) || ((state_q == READ) && ReadOutValid);
`endif

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        leaf_d     = leaf_q;
        occ_base_d = occ_base_q;
        err_d      = err_q;
        bitmap_d   = bitmap_q;
        blk_d      = blk_q;
        cnt_d      = cnt_q;
        dbase_d    = dbase_q;
        rbeat_d    = rbeat_q;
        rbad_d     = rbad_q;
        dly_d      = dly_q;
        acc_d      = acc_q;
        done_d     = 1'b0;
`ifdef STASH_EXERCISER_TIMEOUT_EN
        wd_d       = wd_q;
`endif

        if (WriteInValid && WriteInReady) begin
            cnt_d = cnt_q + DataWidth'(1);
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = SCAN;
                    mode_d     = Mode;
                    base_d     = BaseAddr;
                    leaf_d     = Mode ? ~AccessLeaf : AccessLeaf;
                    occ_base_d = StashOccupancy;
                    dbase_d    = cnt_q;
                    err_d      = '0;
                    bitmap_d   = '0;
                    blk_d      = '0;
                    rbeat_d    = '0;
                    rbad_d     = 1'b0;
                end
            end
            SCAN: begin
                dly_d   = '0;
                state_d = (ScanDelay == 0) ? WRITE : DELAY;
            end
            DELAY: begin
                if (dly_q == DlyW'(ScanDelay - 1)) begin
                    state_d = WRITE;
                end else begin
                    dly_d = dly_q + DlyW'(1);
                end
            end
            WRITE: begin
                if (BlockWriteComplete) begin
                    if (blk_q == IdxW'(BlocksPerPath - 1)) begin
                        blk_d   = '0;
                        state_d = READ_START;
                    end else begin
                        blk_d = blk_q + IdxW'(1);
                    end
                end
            end
            READ_START: state_d = READ;
            READ: begin
                // Invalid blocks are only flagged once, at their last beat
                if (real_fire) begin
                    if (!beat_bad && (ReadData != exp_data)) begin
                        err_d[0] = 1'b1;
                    end
                    if (BlockReadComplete) begin
                        rbeat_d = '0;
                        rbad_d  = 1'b0;
                        if (blk_bad) begin
                            err_d[1] = 1'b1;
                        end else if (bitmap_q[ridx]) begin
                            err_d[2] = 1'b1;
                        end else begin
                            bitmap_d[ridx] = 1'b1;
                        end
                    end else begin
                        rbeat_d = rbeat_q + BeatW'(1);
                        rbad_d  = blk_bad;
                    end
                end
                if (PathReadComplete) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!mode_q) begin
                    if (!(&bitmap_q)) err_d[3] = 1'b1;
                    if (StashOccupancy != occ_base_q) err_d[4] = 1'b1;
                end else begin
                    if (|bitmap_q) err_d[3] = 1'b1;
                    if (StashOccupancy != occ_base_q + StashEAWidth'(BlocksPerPath)) err_d[4] = 1'b1;
                end
                state_d = IDLE;
                done_d  = 1'b1;
                acc_d   = acc_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && StashOverflow) begin
            err_d[5] = 1'b1;
        end

`ifdef STASH_EXERCISER_TIMEOUT_EN
        if (wd_expired) begin
            err_d[6] = 1'b1;
            state_d  = CHECK;
        end
        if ((state_d != state_q) || beat_accept) begin
            wd_d = '0;
        end else if (state_q != IDLE) begin
            wd_d = wd_q + 20'd1;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            base_q     <= '0;
            leaf_q     <= '0;
            occ_base_q <= '0;
            err_q      <= '0;
            bitmap_q   <= '0;
            blk_q      <= '0;
            cnt_q      <= '0;
            dbase_q    <= '0;
            rbeat_q    <= '0;
            rbad_q     <= 1'b0;
            dly_q      <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
`ifdef STASH_EXERCISER_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            leaf_q     <= leaf_d;
            occ_base_q <= occ_base_d;
            err_q      <= err_d;
            bitmap_q   <= bitmap_d;
            blk_q      <= blk_d;
            cnt_q      <= cnt_d;
            dbase_q    <= dbase_d;
            rbeat_q    <= rbeat_d;
            rbad_q     <= rbad_d;
            dly_q      <= dly_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
`ifdef STASH_EXERCISER_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign StartScanOperation = (state_q == SCAN);
    assign StartReadOperation = (state_q == READ_START);
    assign WriteInValid       = (state_q == WRITE);
    assign ReadOutReady       = (state_q == READ);
    assign Busy               = (state_q != IDLE);
    assign Done               = done_q;
    assign WriteData          = cnt_q;
    assign WritePAddr         = base_q + ORAMU'(blk_q);
    assign WriteLeaf          = leaf_q;
    assign ErrorFlags         = err_q;
    assign AccessCount        = acc_q;

endmodule

// File: tb/tb_stash_path_exerciser.sv
// Directed bench for stash_path_exerciser: a small Stash model answers writes and replays
// chosen read orders; expected flags come from a set-based model plus literal pins.
module tb_stash_path_exerciser;
    logic        Clock, Reset, Start, Mode;
    logic [31:0] BaseAddr, AccessLeaf;
    logic        StartScanOperation, StartReadOperation;
    logic [63:0] WriteData;
    logic [31:0] WritePAddr, WriteLeaf;
    logic        WriteInValid, WriteInReady, BlockWriteComplete;
    logic [63:0] ReadData;
    logic [31:0] ReadPAddr, ReadLeaf;
    logic        ReadOutValid, ReadOutReady, BlockReadComplete, PathReadComplete;
    logic [7:0]  StashOccupancy;
    logic        StashOverflow;
    logic        Busy, Done;
    logic [6:0]  ErrorFlags;
    logic [15:0] AccessCount;

    int          testsRun = 0;
    int          failures = 0;
    int          doneSeen = 0;
    int          expAcc   = 0;
    logic [63:0] modelCnt;
    logic [31:0] expBase, expLeaf;
    logic [63:0] mem [4][8];
    logic [31:0] memPAddr [4];
    logic [31:0] memLeaf [4];
    int          wBlk, wBeat;
    bit          wrRdy, toggleReady, got;
    logic [7:0]  occBase, occAdded, occRemoved;
    int          ord [4];

    assign StashOccupancy = occBase + occAdded - occRemoved;

    stash_path_exerciser #(
        .DataWidth(64), .ORAMU(32), .ORAML(32), .StashEAWidth(8),
        .BlocksPerPath(4), .BeatsPerBlock(8), .ScanDelay(10)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Mode(Mode),
        .BaseAddr(BaseAddr), .AccessLeaf(AccessLeaf),
        .StartScanOperation(StartScanOperation), .StartReadOperation(StartReadOperation),
        .WriteData(WriteData), .WritePAddr(WritePAddr), .WriteLeaf(WriteLeaf),
        .WriteInValid(WriteInValid), .WriteInReady(WriteInReady),
        .BlockWriteComplete(BlockWriteComplete),
        .ReadData(ReadData), .ReadPAddr(ReadPAddr), .ReadLeaf(ReadLeaf),
        .ReadOutValid(ReadOutValid), .ReadOutReady(ReadOutReady),
        .BlockReadComplete(BlockReadComplete), .PathReadComplete(PathReadComplete),
        .StashOccupancy(StashOccupancy), .StashOverflow(StashOverflow),
        .Busy(Busy), .Done(Done), .ErrorFlags(ErrorFlags), .AccessCount(AccessCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        failures++;
        $display("[TB] FAIL %s: event never arrived, required within cycle budget", name);
    endtask

    // Stash write side: accepts beats, checks them against a running beat counter, stores them
    initial begin
        modelCnt = '0; wBlk = 0; wBeat = 0; occAdded = '0; wrRdy = 1'b0;
        WriteInReady = 1'b0; BlockWriteComplete = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                modelCnt = '0; wBlk = 0; wBeat = 0; occAdded = '0; wrRdy = 1'b0;
                WriteInReady = 1'b0; BlockWriteComplete = 1'b0;
            end else if (!Busy) begin
                wBlk = 0; wBeat = 0; occAdded = '0;
                WriteInReady = 1'b0; BlockWriteComplete = 1'b0;
            end else begin
                wrRdy = toggleReady ? !wrRdy : 1'b1;
                WriteInReady = wrRdy;
                BlockWriteComplete = wrRdy && WriteInValid && (wBeat == 7);
                if (WriteInValid && wrRdy) begin
                    checkOutput("wrData", WriteData, modelCnt);
                    checkOutput("wrPAddr", 64'(WritePAddr), 64'(expBase + 32'(wBlk)));
                    checkOutput("wrLeaf", 64'(WriteLeaf), 64'(expLeaf));
                    if (wBlk < 4) begin
                        mem[wBlk][wBeat] = WriteData;
                        memPAddr[wBlk]   = WritePAddr;
                        memLeaf[wBlk]    = WriteLeaf;
                    end
                    modelCnt = modelCnt + 64'd1;
                    wBeat++;
                    if (wBeat == 8) begin
                        wBeat = 0;
                        wBlk++;
                        occAdded = occAdded + 8'd1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (Done === 1'b1) doneSeen++;
        end
    end

    task automatic sendBlock(input logic [31:0] paddr, input logic [31:0] leaf, input int blk,
                             input int corruptBeat, input bit isReal);
        for (int b = 0; b < 8; b++) begin
            @(negedge Clock);
            ReadOutValid      = 1'b1;
            ReadPAddr         = paddr;
            ReadLeaf          = leaf;
            ReadData          = isReal ? mem[blk][b] : (64'hdead_0000 + 64'(b));
            if (b == corruptBeat) ReadData = ReadData ^ 64'h1;
            BlockReadComplete = (b == 7);
            if (isReal && b == 7) occRemoved = occRemoved + 8'd1;
        end
    endtask

    // One full access; ord[] holds the block return order (-1 = nothing returned in that slot)
    task automatic applyStimulus(input bit mode, input logic [31:0] base, input logic [31:0] leaf,
                                 input logic [7:0] occb, input int corruptBlk, input int badLeafBlk,
                                 input bit ovf, input int extraStarts, input logic [6:0] pinFlags);
        logic [63:0] dbase, d;
        logic [31:0] wleaf, pl, idx;
        logic [7:0]  occFinal, occExp;
        logic [6:0]  expFlags;
        bit [3:0]    seen;
        int          nRet, blk, startDone;
        bit          ok;
        expFlags = '0; seen = '0; nRet = 0;
        wleaf = mode ? ~leaf : leaf;
        expBase = base; expLeaf = wleaf; occBase = occb; occRemoved = '0;
        dbase = modelCnt;
        startDone = doneSeen;
        @(negedge Clock);
        Mode = mode; BaseAddr = base; AccessLeaf = leaf; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int k = 0; k < extraStarts; k++) begin
            Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            @(negedge Clock);
        end
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            if (StartReadOperation) ok = 1'b1;
            else @(negedge Clock);
        end
        if (!ok) reportTimeout("startRead");
        sendBlock(32'hffff_ffff, 32'h0, 0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (ord[k] >= 0) begin
                blk = ord[k];
                pl  = memLeaf[blk] ^ ((blk == badLeafBlk) ? 32'h1 : 32'h0);
                if (ovf && k == 0) StashOverflow = 1'b1;
                sendBlock(memPAddr[blk], pl, blk, (blk == corruptBlk) ? 3 : -1, 1'b1);
                StashOverflow = 1'b0;
                nRet++;
                idx = memPAddr[blk] - base;
                if (idx < 32'd4 && pl == wleaf) begin
                    for (int b = 0; b < 8; b++) begin
                        d = mem[blk][b] ^ ((blk == corruptBlk && b == 3) ? 64'h1 : 64'h0);
                        if (d != dbase + 64'(idx) * 64'd8 + 64'(b)) expFlags[0] = 1'b1;
                    end
                    if (seen[idx[1:0]]) expFlags[2] = 1'b1;
                    else seen[idx[1:0]] = 1'b1;
                end else begin
                    expFlags[1] = 1'b1;
                end
            end
        end
        @(negedge Clock);
        ReadOutValid = 1'b0; BlockReadComplete = 1'b0; PathReadComplete = 1'b1;
        @(negedge Clock);
        PathReadComplete = 1'b0;
        occFinal = occb + 8'd4 - 8'(nRet);
        occExp   = mode ? (occb + 8'd4) : occb;
        if (mode ? (seen != 4'h0) : (seen != 4'hf)) expFlags[3] = 1'b1;
        if (occFinal != occExp) expFlags[4] = 1'b1;
        if (ovf) expFlags[5] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (Done) ok = 1'b1;
            else @(negedge Clock);
        end
        if (!ok) reportTimeout("donePulse");
        expAcc++;
        checkOutput("flagsModel", 64'(ErrorFlags), 64'(expFlags));
        checkOutput("flagsPinned", 64'(ErrorFlags), 64'(pinFlags));
        checkOutput("busyAtDone", 64'(Busy), 64'd0);
        checkOutput("accessCount", 64'(AccessCount), 64'(expAcc));
        repeat (3) @(negedge Clock);
        checkOutput("doneCount", 64'(doneSeen - startDone), 64'd1);
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Mode = 1'b0; BaseAddr = '0; AccessLeaf = '0;
        ReadData = '0; ReadPAddr = '0; ReadLeaf = '0; ReadOutValid = 1'b0;
        BlockReadComplete = 1'b0; PathReadComplete = 1'b0; StashOverflow = 1'b0;
        toggleReady = 1'b0; occBase = '0; occRemoved = '0; expBase = '0; expLeaf = '0;
        repeat (3) @(negedge Clock);
        checkOutput("rstBusy", 64'(Busy), 64'd0);
        checkOutput("rstWrValid", 64'(WriteInValid), 64'd0);
        checkOutput("rstWrData", WriteData, 64'd0);
        checkOutput("rstFlags", 64'(ErrorFlags), 64'd0);
        checkOutput("rstAccCount", 64'(AccessCount), 64'd0);
        checkOutput("rstDone", 64'(Done), 64'd0);
        Reset = 1'b1;
        @(negedge Clock);

        ord = '{2, 3, 0, 1};
        applyStimulus(1'b0, 32'hf000_0000, 32'h0000_ffff, 8'd0, -1, -1, 1'b0, 0, 7'h00);
        checkOutput("blk2Base", mem[2][0], 64'd16);
        checkOutput("blk3Base", mem[3][0], 64'd24);
        checkOutput("blk1Base", mem[1][0], 64'd8);

        ord = '{-1, -1, -1, -1};
        applyStimulus(1'b1, 32'hf000_0004, 32'h0000_ffff, 8'd254, -1, -1, 1'b0, 0, 7'h00);
        checkOutput("dataCounter", WriteData, 64'd64);
        checkOutput("mode1Leaf", 64'(WriteLeaf), 64'h0000_0000_ffff_0000);

        ord = '{0, 1, 2, 3};
        applyStimulus(1'b0, 32'h0000_1000, 32'h0000_0abc, 8'd7, 1, -1, 1'b0, 0, 7'h01);

        ord = '{0, 1, 2, 2};
        applyStimulus(1'b0, 32'h0000_2000, 32'h0000_0abc, 8'd7, -1, -1, 1'b0, 0, 7'h0c);

        toggleReady = 1'b1;
        ord = '{3, 2, 1, 0};
        applyStimulus(1'b0, 32'h0000_3000, 32'h1234_5678, 8'd2, -1, -1, 1'b0, 3, 7'h00);
        toggleReady = 1'b0;

        ord = '{0, 1, 2, 3};
        applyStimulus(1'b0, 32'h0000_4000, 32'h0000_0001, 8'd0, -1, -1, 1'b1, 0, 7'h20);

        ord = '{0, 1, 2, 3};
        applyStimulus(1'b0, 32'h0000_5000, 32'h0000_0002, 8'd0, -1, 0, 1'b0, 0, 7'h0a);

        // Reset in the middle of the write phase, then a clean access from a zeroed counter
        expBase = 32'h100; expLeaf = 32'h5; occBase = '0; occRemoved = '0;
        @(negedge Clock);
        Mode = 1'b0; BaseAddr = 32'h100; AccessLeaf = 32'h5; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (WriteInValid) got = 1'b1;
            else @(negedge Clock);
        end
        if (!got) reportTimeout("writePhase");
        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("midRstBusy", 64'(Busy), 64'd0);
        checkOutput("midRstWrValid", 64'(WriteInValid), 64'd0);
        checkOutput("midRstWrData", WriteData, 64'd0);
        checkOutput("midRstWrPAddr", 64'(WritePAddr), 64'd0);
        checkOutput("midRstWrLeaf", 64'(WriteLeaf), 64'd0);
        checkOutput("midRstFlags", 64'(ErrorFlags), 64'd0);
        checkOutput("midRstAccCount", 64'(AccessCount), 64'd0);
        checkOutput("midRstStrobes", 64'({StartScanOperation, StartReadOperation, ReadOutReady, Done}), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        expAcc = 0;
        @(negedge Clock);
        ord = '{1, 0, 3, 2};
        applyStimulus(1'b0, 32'h0000_0200, 32'h0000_0033, 8'd9, -1, -1, 1'b0, 0, 7'h00);
        checkOutput("postRstBase", mem[0][0], 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end
endmodule
